led_function_core: RTL and testbench

Six-digit display controller. Receives ASCII commands and digits over a UART line and drives six 5-bit digit codes to the downstream 7-segment decoder/multiplexer. The displayed digits rotate one position every `TURNS` clock cycles. The UART receiver is embedded in the block.

---
 rtl/led_function_pkg.sv | 61 ++++++
 rtl/uart_rx.sv | 97 +++++++++
 rtl/led_function_core.sv | 99 +++++++++
 tb/tb_led_function_core.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_function_pkg.sv
// Shared types and constants for the six-digit rotating display controller.
package led_function_pkg;

    // Default timing: 0.5 s per rotation step and 9600 baud, both at 50 MHz.
    localparam int TURNS_DEFAULT        = 25_000_000;
    localparam int CLKS_PER_BIT_DEFAULT = 5208;

    // 5-bit code sent to the 7-segment decoder: 0-9 are digits, 1F is blank.
    typedef logic [4:0] digit_t;
    localparam digit_t CODE_BLANK = 5'h1F;

    // ASCII command bytes, upper and lower case.
    localparam logic [7:0] CMD_PLAY_U  = 8'h47;  // 'G'
    localparam logic [7:0] CMD_PLAY_L  = 8'h67;  // 'g'
    localparam logic [7:0] CMD_PAUSE_U = 8'h50;  // 'P'
    localparam logic [7:0] CMD_PAUSE_L = 8'h70;  // 'p'
    localparam logic [7:0] CMD_DIR_U   = 8'h44;  // 'D'
    localparam logic [7:0] CMD_DIR_L   = 8'h64;  // 'd'
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;

    // Receiver frame states.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Decoded meaning of a received byte.
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_PLAY,
        CMD_PAUSE,
        CMD_DIR,
        CMD_DIGIT
    } cmd_t;

    // Classify one received byte; anything unrecognised maps to CMD_NONE.
    function automatic cmd_t decode_cmd(input logic [7:0] b);
        cmd_t c;
        c = CMD_NONE;
        case (b)
            CMD_PLAY_U, CMD_PLAY_L:   c = CMD_PLAY;
            CMD_PAUSE_U, CMD_PAUSE_L: c = CMD_PAUSE;
            CMD_DIR_U, CMD_DIR_L:     c = CMD_DIR;
            default: begin
                if (b >= ASCII_0 && b <= ASCII_9) c = CMD_DIGIT;
            end
        endcase
        return c;
    endfunction

    // Convert an ASCII digit to its display code (caller guarantees '0'..'9').
    function automatic digit_t ascii_to_digit(input logic [7:0] b);
        logic [7:0] d;
        d = b - ASCII_0;
        return d[4:0];
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer and mid-bit sampling.
// Output handshake: rx_valid is a one-cycle strobe with no ready; rx_byte is
// valid in that cycle and the consumer must take it then.
module uart_rx
    import led_function_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid
);

    localparam int CNT_W   = $clog2(CLKS_PER_BIT + 1);
    localparam int HALF_M1 = (CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0;
    // Start bit is re-checked half a bit after the synchronized falling edge;
    // from there every sample lands one full bit later, i.e. mid-bit.
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_M1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta;
    logic             rx_sync;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    // Bring the asynchronous line into the clock domain; idle level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Frame FSM: IDLE -> START -> DATA x8 -> STOP -> IDLE, registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_CNT) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // A line that is high again at mid-start was a glitch.
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_END) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7) state <= RX_STOP;
                        else bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_END) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        // A low stop bit is a framing error: drop the byte.
                        if (rx_sync) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= shreg;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/led_function_core.sv
// Six-digit display controller: UART commands insert digits, pause/play the
// rotation and flip its direction; digits rotate one place every TURNS cycles.
module led_function_core
    import led_function_pkg::*;
#(
    parameter int TURNS        = TURNS_DEFAULT,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [4:0] in0,
    output logic [4:0] in1,
    output logic [4:0] in2,
    output logic [4:0] in3,
    output logic [4:0] in4,
    output logic [4:0] in5
);

    localparam int TICK_W = $clog2(TURNS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TURNS - 1);

    logic [7:0]        rx_byte;
    logic              rx_valid;
    cmd_t              cmd;
    logic              run;
    logic              dir;
    logic              step;
    logic [TICK_W-1:0] tick_cnt;
    digit_t            digits [6];

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid)
    );

    // Decode the received byte only in its valid cycle; a step fires on the
    // last count while running (old run/dir apply even if a command lands now).
    always_comb begin
        cmd  = CMD_NONE;
        if (rx_valid) cmd = decode_cmd(rx_byte);
        step = run && (tick_cnt == TICK_LAST);
    end

    // Rotation tick counter: free-runs and wraps while running, holds when paused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (run) begin
            tick_cnt <= step ? '0 : tick_cnt + 1'b1;
        end
    end

    // Play/pause and direction flags, updated the cycle after the byte arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b1;
            dir <= 1'b0;
        end else begin
            case (cmd)
                CMD_PLAY:  run <= 1'b1;
                CMD_PAUSE: run <= 1'b0;
                CMD_DIR:   dir <= ~dir;
                default:   ;
            endcase
        end
    end

    // Digit register: a digit insertion takes priority over a coincident step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 6; k++) digits[k] <= digit_t'(k);
        end else if (cmd == CMD_DIGIT) begin
            for (int k = 5; k > 0; k--) digits[k] <= digits[k-1];
            digits[0] <= ascii_to_digit(rx_byte);
        end else if (step) begin
            if (!dir) begin
                for (int k = 5; k > 0; k--) digits[k] <= digits[k-1];
                digits[0] <= digits[5];
            end else begin
                for (int k = 0; k < 5; k++) digits[k] <= digits[k+1];
                digits[5] <= digits[0];
            end
        end
    end

    assign in0 = digits[0];
    assign in1 = digits[1];
    assign in2 = digits[2];
    assign in3 = digits[3];
    assign in4 = digits[4];
    assign in5 = digits[5];

endmodule

// File: tb/tb_led_function_core.sv
// Bench for led_function_core with TURNS=8, CLKS_PER_BIT=4.
module tb_led_function_core;

    localparam int TURNS = 8;
    localparam int CPB   = 4;
    localparam int W     = 30;
    localparam logic [W-1:0] RESET_DISP = {5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};

    // ---------------- clock / reset / DUT ----------------
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [4:0] in0, in1, in2, in3, in4, in5;
    logic [W-1:0] disp;

    assign disp = {in5, in4, in3, in2, in1, in0};

    led_function_core #(
        .TURNS       (TURNS),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (rx),
        .in0  (in0),
        .in1  (in1),
        .in2  (in2),
        .in3  (in3),
        .in4  (in4),
        .in5  (in5)
    );

    always #5 clk = ~clk;

    // Cycles since reset release: the first rising edge after release is 1.
    int cyc = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m;
    logic [W-1:0] prev_disp;
    int checks  = 0;
    int errors  = 0;
    int chg_cyc = 0;
    int lat     = 42;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h want %h (cyc %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Every display change must match the next expected display value.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_disp = disp;
        end else if (disp !== prev_disp) begin
            chg_cyc = cyc;
            if (exp_q.size() > 0) check("disp", 32'(disp), 32'(exp_q.pop_front()));
            else                  check("unexpected_change", 32'(disp), 32'(prev_disp));
            prev_disp = disp;
        end
    end

    // Display model helpers, packed as {in5..in0}.
    function automatic logic [W-1:0] fwd(input logic [W-1:0] v);
        return {v[24:0], v[29:25]};
    endfunction

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        return {v[4:0], v[29:5]};
    endfunction

    task automatic push_fwd(input int n);
        repeat (n) begin m = fwd(m); exp_q.push_back(m); end
    endtask

    task automatic push_rev(input int n);
        repeat (n) begin m = rev(m); exp_q.push_back(m); end
    endtask

    task automatic push_ins(input logic [4:0] d);
        m = {m[24:0], d};
        exp_q.push_back(m);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_disp", 32'(disp), 32'(RESET_DISP));
        check("q_empty_before_reset", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        m     = RESET_DISP;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop_bit;
        repeat (CPB) tick();
        rx = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int c0;
        int e;

        // Reset and free-running rotation.
        do_reset();
        push_fwd(2);
        wait_cyc(7);
        check("pre_first_step", 32'(disp), 32'(RESET_DISP));
        wait_cyc(8);
        check("first_step", 32'(disp), 32'(fwd(RESET_DISP)));
        wait_cyc(17);
        check("second_step", 32'(disp), 32'(fwd(fwd(RESET_DISP))));
        check("q_reset_steps", 32'(exp_q.size()), 32'd0);

        // Pause lands between steps (~cycle 60): five more steps, then frozen.
        wait_cyc(18);
        push_fwd(5);
        send_byte(8'h50, 1'b1);
        wait_cyc(100);
        check("q_pause", 32'(exp_q.size()), 32'd0);
        check("frozen", 32'(disp), 32'(m));
        send_byte(8'h70, 1'b1);
        wait_cyc(150);
        check("still_paused", 32'(disp), 32'(m));
        send_byte(8'h67, 1'b1);
        push_fwd(1);
        wait_cyc(200);
        check("q_resume", 32'(exp_q.size()), 32'd0);
        check("resume_disp", 32'(disp), 32'(m));

        // Direction: 'D' lands ~cycle 44, 'd' lands ~cycle 100.
        do_reset();
        wait_cyc(2);
        push_fwd(5);
        push_rev(7);
        push_fwd(2);
        send_byte(8'h44, 1'b1);
        wait_cyc(58);
        send_byte(8'h64, 1'b1);
        wait_cyc(115);
        check("q_dir", 32'(exp_q.size()), 32'd0);
        check("dir_disp", 32'(disp), 32'(m));

        // Digit insertion while paused; also measures byte-to-output latency.
        do_reset();
        wait_cyc(2);
        push_fwd(5);
        send_byte(8'h50, 1'b1);
        wait_cyc(50);
        check("q_pause2", 32'(exp_q.size()), 32'd0);
        push_ins(5'd4);
        send_byte(8'h34, 1'b1);
        while (chg_cyc < 50 && cyc < 120) tick();
        lat = chg_cyc - 50;
        check("latency_in_range", 32'(lat >= 38 && lat <= 46), 32'd1);
        if (lat < 38 || lat > 46) lat = 42;
        wait_cyc(100);
        push_ins(5'd5);
        send_byte(8'h35, 1'b1);
        wait_cyc(150);
        push_ins(5'd6);
        send_byte(8'h36, 1'b1);
        wait_cyc(200);
        send_byte(8'h78, 1'b1);
        wait_cyc(250);
        check("q_digits", 32'(exp_q.size()), 32'd0);
        check("digits_disp", 32'(disp), 32'(m));

        // Framing: bad stop bit and a one-cycle glitch are both ignored.
        send_byte(8'h37, 1'b0);
        wait_cyc(300);
        rx = 1'b0;
        tick();
        rx = 1'b1;
        wait_cyc(320);
        check("framing_no_change", 32'(disp), 32'(m));
        push_ins(5'd8);
        send_byte(8'h38, 1'b1);
        wait_cyc(370);
        check("q_framing", 32'(exp_q.size()), 32'd0);
        check("framing_disp", 32'(disp), 32'(m));

        // Collision: digit lands on a step edge, so that step is dropped.
        do_reset();
        c0 = 2;
        while ((c0 + lat) % TURNS != 0) c0++;
        e = c0 + lat;
        push_fwd(e / TURNS - 1);
        push_ins(5'd9);
        push_fwd(1);
        wait_cyc(c0);
        send_byte(8'h39, 1'b1);
        wait_cyc(e + TURNS + 2);
        check("q_collision", 32'(exp_q.size()), 32'd0);
        check("collision_disp", 32'(disp), 32'(m));

        // Reset mid-frame, then a clean frame is received.
        do_reset();
        push_fwd(1);
        wait_cyc(2);
        rx = 1'b0;
        wait_cyc(14);
        check("q_pre_async_reset", 32'(exp_q.size()), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_reset_disp", 32'(disp), 32'(RESET_DISP));
        rx = 1'b1;
        repeat (2) @(negedge clk);
        m     = RESET_DISP;
        rst_n = 1'b1;
        tick();
        c0 = 2;
        while ((c0 + lat) % TURNS != 4) c0++;
        e = c0 + lat;
        push_fwd((e - 4) / TURNS);
        push_ins(5'd3);
        push_fwd(1);
        wait_cyc(c0);
        send_byte(8'h33, 1'b1);
        wait_cyc(e + 6);
        check("q_after_midframe_reset", 32'(exp_q.size()), 32'd0);
        check("midframe_reset_disp", 32'(disp), 32'(m));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
